// File: rtl/health_alarm_manager.sv
// Debounces five raw abnormality flags into sticky alarms and timestamped events queued in a FWFT FIFO.
// Latency: confirm DEBOUNCE edges after the first high sample, FIFO push one edge later.
// Backpressure: evt_ready low holds the head entry; onsets wait in pending bits and a repeat onset is counted in drop_cnt.

module health_evt_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_vld,
    input  logic [W-1:0]             in_dat,
    output logic                     in_rdy,
    output logic                     out_vld,
    output logic [W-1:0]             out_dat,
    input  logic                     out_rdy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign out_vld = (count != '0);
    assign pop     = out_vld & out_rdy;
    // A full FIFO still takes a write in the cycle its head is popped.
    assign in_rdy  = (count != FULL_CNT) | pop;
    assign push    = in_vld & in_rdy;
    assign out_dat = out_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module health_alarm_manager #(
    parameter int DEBOUNCE = 4,
    parameter int DEPTH    = 8,
    parameter int TS_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     presureAbnormality,
    input  logic                     bloodAbnormality,
    input  logic                     fallDetected,
    input  logic                     lowTempAbnormality,
    input  logic                     highTempAbnormality,
    input  logic [4:0]               ack_mask,
    input  logic                     evt_ready,
    output logic                     evt_valid,
    output logic [2:0]               evt_code,
    output logic [TS_W-1:0]          evt_time,
    output logic [4:0]               alarm_status,
    output logic                     alarm_any,
    output logic [2:0]               alarm_top,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               drop_cnt
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE);
    localparam logic [CW-1:0] DB_ARM = CW'(DEBOUNCE - 1);

    typedef struct packed {
        logic [2:0]      code;
        logic [TS_W-1:0] ts;
    } evt_t;

    logic [4:0]      raw;
    logic [CW-1:0]   db_cnt [5];
    logic [4:0]      confirm;
    logic [4:0]      pending;
    logic [4:0]      push_sel;
    logic [4:0]      push_clr;
    logic [4:0]      merged;
    logic [2:0]      push_code;
    logic [2:0]      n_merged;
    logic [8:0]      drop_sum;
    logic [TS_W-1:0] ts;
    logic            push_vld;
    logic            push_rdy;
    evt_t            push_evt;
    evt_t            head_evt;

    // Bit index is the source code, which is also the priority order.
    assign raw = {lowTempAbnormality, highTempAbnormality, bloodAbnormality,
                  presureAbnormality, fallDetected};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (!raw[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != DB_MAX) begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        confirm = '0;
        for (int i = 0; i < 5; i++) begin
            confirm[i] = raw[i] && (db_cnt[i] == DB_ARM);
        end
    end

    always_comb begin
        push_sel  = '0;
        push_code = '0;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) begin
                push_sel    = '0;
                push_sel[i] = 1'b1;
                push_code   = 3'(i);
            end
        end
    end

    assign push_vld      = |pending;
    assign push_evt.code = push_code;
    assign push_evt.ts   = ts;
    assign push_clr      = (push_vld && push_rdy) ? push_sel : 5'b0;
    // An onset only merges if its earlier event is not leaving on this same edge.
    assign merged        = confirm & pending & ~push_clr;

    always_comb begin
        n_merged = '0;
        for (int i = 0; i < 5; i++) begin
            n_merged = n_merged + {2'b0, merged[i]};
        end
        drop_sum = {1'b0, drop_cnt} + {6'b0, n_merged};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            alarm_status <= '0;
            drop_cnt     <= '0;
        end else begin
            pending      <= (pending & ~push_clr) | confirm;
            alarm_status <= (alarm_status & ~ack_mask) | confirm;
            drop_cnt     <= drop_sum[8] ? 8'hff : drop_sum[7:0];
        end
    end

    always_comb begin
        alarm_top = 3'd7;
        for (int i = 4; i >= 0; i--) begin
            if (alarm_status[i]) begin
                alarm_top = 3'(i);
            end
        end
    end

    assign alarm_any = |alarm_status;

    health_evt_fifo #(
        .W     ($bits(evt_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (push_vld),
        .in_dat  (push_evt),
        .in_rdy  (push_rdy),
        .out_vld (evt_valid),
        .out_dat (head_evt),
        .out_rdy (evt_ready),
        .count   (fifo_count)
    );

    assign evt_code = head_evt.code;
    assign evt_time = head_evt.ts;
endmodule

// File: tb/tb_health_alarm_manager.sv
// Directed bench for health_alarm_manager: vector table for single-source behaviour,
// hand-written sequences for queueing, merging, ack races and mid-run reset.
module tb_health_alarm_manager;
    localparam int DEBOUNCE = 4;
    localparam int DEPTH    = 8;
    localparam int TS_W     = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            presureAbnormality = 1'b0;
    logic            bloodAbnormality = 1'b0;
    logic            fallDetected = 1'b0;
    logic            lowTempAbnormality = 1'b0;
    logic            highTempAbnormality = 1'b0;
    logic [4:0]      ack_mask = 5'b0;
    logic            evt_ready = 1'b0;
    logic            evt_valid;
    logic [2:0]      evt_code;
    logic [TS_W-1:0] evt_time;
    logic [4:0]      alarm_status;
    logic            alarm_any;
    logic [2:0]      alarm_top;
    logic [3:0]      fifo_count;
    logic [7:0]      drop_cnt;

    health_alarm_manager #(.DEBOUNCE(DEBOUNCE), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .presureAbnormality  (presureAbnormality),
        .bloodAbnormality    (bloodAbnormality),
        .fallDetected        (fallDetected),
        .lowTempAbnormality  (lowTempAbnormality),
        .highTempAbnormality (highTempAbnormality),
        .ack_mask            (ack_mask),
        .evt_ready           (evt_ready),
        .evt_valid           (evt_valid),
        .evt_code            (evt_code),
        .evt_time            (evt_time),
        .alarm_status        (alarm_status),
        .alarm_any           (alarm_any),
        .alarm_top           (alarm_top),
        .fifo_count          (fifo_count),
        .drop_cnt            (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  flags;
        logic [4:0]  ack;
        logic        rdy;
        logic [4:0]  st;
        logic        vld;
        logic [2:0]  code;
        logic [15:0] tm;
        logic [3:0]  cnt;
        logic [7:0]  drop;
    } vec_t;

    vec_t vecs [15];
    int   n_vec = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   edges = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bit order matches the source codes: 0 fall, 1 pressure, 2 blood, 3 highTemp, 4 lowTemp.
    task automatic set_flags(input logic [4:0] f);
        fallDetected        = f[0];
        presureAbnormality  = f[1];
        bloodAbnormality    = f[2];
        highTempAbnormality = f[3];
        lowTempAbnormality  = f[4];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic add_vec(input logic [4:0] f, input logic [4:0] a, input logic r,
                           input logic [4:0] st, input logic v, input logic [2:0] c,
                           input logic [15:0] t, input logic [3:0] n, input logic [7:0] d);
        vecs[n_vec] = '{f, a, r, st, v, c, t, n, d};
        n_vec++;
    endtask

    function automatic logic [2:0] top_of(input logic [4:0] st);
        logic [2:0] r;
        r = 3'd7;
        for (int i = 4; i >= 0; i--) if (st[i]) r = 3'(i);
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e_c;
        int base;
        int waited;
        logic [4:0] seq [18];
        int exp_code [8];
        int exp_off  [8];

        // single fall onset, then a blood glitch that never reaches DEBOUNCE samples
        add_vec(5'b00001, 5'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00001, 5'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00001, 5'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00001, 5'b0, 1'b1, 5'b00001, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00001, 5'b0, 1'b1, 5'b00001, 1'b1, 3'd0, 16'd4, 4'd1, 8'd0);
        add_vec(5'b00001, 5'b0, 1'b1, 5'b00001, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00000, 5'b00001, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00100, 5'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00100, 5'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00100, 5'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00000, 5'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00100, 5'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00100, 5'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00100, 5'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);
        add_vec(5'b00000, 5'b0, 1'b1, 5'b00000, 1'b0, 3'd0, 16'd0, 4'd0, 8'd0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst evt_valid", 32'(evt_valid), 0);
        check("rst evt_code", 32'(evt_code), 0);
        check("rst evt_time", 32'(evt_time), 0);
        check("rst alarm_status", 32'(alarm_status), 0);
        check("rst alarm_any", 32'(alarm_any), 0);
        check("rst alarm_top", 32'(alarm_top), 7);
        check("rst fifo_count", 32'(fifo_count), 0);
        check("rst drop_cnt", 32'(drop_cnt), 0);
        #2;
        rst_n = 1'b1;
        edges = 0;

        for (int k = 0; k < n_vec; k++) begin
            set_flags(vecs[k].flags);
            ack_mask  = vecs[k].ack;
            evt_ready = vecs[k].rdy;
            tick();
            check($sformatf("vec%0d alarm_status", k), 32'(alarm_status), 32'(vecs[k].st));
            check($sformatf("vec%0d alarm_top", k), 32'(alarm_top), 32'(top_of(vecs[k].st)));
            check($sformatf("vec%0d alarm_any", k), 32'(alarm_any), 32'(|vecs[k].st));
            check($sformatf("vec%0d evt_valid", k), 32'(evt_valid), 32'(vecs[k].vld));
            check($sformatf("vec%0d fifo_count", k), 32'(fifo_count), 32'(vecs[k].cnt));
            check($sformatf("vec%0d drop_cnt", k), 32'(drop_cnt), 32'(vecs[k].drop));
            if (vecs[k].vld) begin
                check($sformatf("vec%0d evt_code", k), 32'(evt_code), 32'(vecs[k].code));
                check($sformatf("vec%0d evt_time", k), 32'(evt_time), 32'(vecs[k].tm));
            end
        end
        ack_mask = 5'b0;

        // all five sources together, downstream stalled
        evt_ready = 1'b0;
        set_flags(5'b11111);
        repeat (DEBOUNCE) tick();
        e_c = edges;
        check("all confirm status", 32'(alarm_status), 32'h1f);
        check("all confirm top", 32'(alarm_top), 0);
        check("all confirm any", 32'(alarm_any), 1);
        check("all confirm count", 32'(fifo_count), 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("all push%0d count", i), 32'(fifo_count), 32'(i));
        end
        check("all queued top", 32'(alarm_top), 0);
        set_flags(5'b00000);
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("all head%0d valid", i), 32'(evt_valid), 1);
            check($sformatf("all head%0d code", i), 32'(evt_code), 32'(i));
            check($sformatf("all head%0d time", i), 32'(evt_time), 32'(e_c + i));
            tick();
        end
        check("all drained valid", 32'(evt_valid), 0);
        check("all drained count", 32'(fifo_count), 0);
        evt_ready = 1'b0;
        ack_mask  = 5'b11111;
        tick();
        ack_mask  = 5'b0;
        check("ack all status", 32'(alarm_status), 0);
        check("ack all top", 32'(alarm_top), 7);
        check("ack all any", 32'(alarm_any), 0);

        // fill the FIFO, leave fall pending, then merge a second fall onset
        base = edges;
        for (int k = 0; k < 4; k++) seq[k] = 5'b11111;
        seq[4] = 5'b00000;
        for (int k = 5; k < 9; k++) seq[k] = 5'b01110;
        for (int k = 9; k < 13; k++) seq[k] = 5'b00001;
        seq[13] = 5'b00000;
        for (int k = 14; k < 18; k++) seq[k] = 5'b00001;
        for (int k = 0; k < 18; k++) begin
            set_flags(seq[k]);
            tick();
            if (k == 11) check("fill count at full", 32'(fifo_count), 8);
            if (k == 12) begin
                check("fill fall pending count", 32'(fifo_count), 8);
                check("fill fall pending drop", 32'(drop_cnt), 0);
            end
        end
        check("merge count", 32'(fifo_count), 8);
        check("merge drop_cnt", 32'(drop_cnt), 1);
        check("merge status", 32'(alarm_status), 32'h1f);
        set_flags(5'b00000);
        evt_ready = 1'b1;
        tick();
        check("pop+push count", 32'(fifo_count), 8);
        exp_code = '{1, 2, 3, 4, 1, 2, 3, 0};
        exp_off  = '{5, 6, 7, 8, 9, 10, 11, 18};
        for (int j = 0; j < 8; j++) begin
            check($sformatf("drain%0d valid", j), 32'(evt_valid), 1);
            check($sformatf("drain%0d code", j), 32'(evt_code), 32'(exp_code[j]));
            check($sformatf("drain%0d time", j), 32'(evt_time), 32'(base + exp_off[j]));
            tick();
        end
        check("drain empty valid", 32'(evt_valid), 0);
        check("drain empty count", 32'(fifo_count), 0);
        evt_ready = 1'b0;

        // ack racing a new pressure confirm
        ack_mask = 5'b11001;
        tick();
        ack_mask = 5'b0;
        check("partial ack status", 32'(alarm_status), 32'h06);
        check("partial ack top", 32'(alarm_top), 1);
        set_flags(5'b00010);
        repeat (DEBOUNCE - 1) tick();
        check("pre-race status", 32'(alarm_status), 32'h06);
        ack_mask = 5'b00110;
        tick();
        ack_mask = 5'b0;
        check("race status", 32'(alarm_status), 32'h02);
        check("race top", 32'(alarm_top), 1);
        check("race any", 32'(alarm_any), 1);
        check("race fifo untouched", 32'(fifo_count), 0);

        // three queued events, fall mid-debounce, then asynchronous reset
        set_flags(5'b01100);
        repeat (DEBOUNCE) tick();
        set_flags(5'b00001);
        repeat (2) tick();
        check("pre-reset count", 32'(fifo_count), 3);
        check("pre-reset status", 32'(alarm_status), 32'h0e);
        check("pre-reset drop", 32'(drop_cnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst evt_valid", 32'(evt_valid), 0);
        check("async rst fifo_count", 32'(fifo_count), 0);
        check("async rst alarm_status", 32'(alarm_status), 0);
        check("async rst drop_cnt", 32'(drop_cnt), 0);
        check("async rst alarm_top", 32'(alarm_top), 7);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        edges = 0;
        waited = 0;
        while (!evt_valid && waited < 20) begin
            tick();
            waited++;
        end
        check("post-reset latency", 32'(waited), 32'(DEBOUNCE + 1));
        check("post-reset code", 32'(evt_code), 0);
        check("post-reset time", 32'(evt_time), 32'(DEBOUNCE));
        check("post-reset count", 32'(fifo_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
